// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: arbiter defaults, FSM encoding
// and the clock/baud pair used by async_transmitter.
package uart_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_HOLD_TIMEOUT = 20000;
  localparam int unsigned DEF_BUSY_WAIT    = 8;

  localparam int unsigned CLK_HZ = 10000000;
  localparam int unsigned BAUD   = 230400;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] arbState_t;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD      = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD      = 3'd4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from lastGrant+1, wrapping at NUM_REQ-1.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [IDX_W-1:0]   lastGrant,
  output logic               pickValid_c,
  output logic [IDX_W-1:0]   pickIdx_c
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    pickValid_c = 1'b0;
    pickIdx_c   = '0;
    cand        = '0;
    for (int unsigned k = NUM_REQ; k != 0; k--) begin
      cand = IDX_W'((32'(lastGrant) + 32'(k)) % NUM_REQ);
      if (reqVec[cand]) begin
        pickValid_c = 1'b1;
        pickIdx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic arbiter sharing one async_transmitter among NUM_REQ byte-stream
// requesters; forces release of an owner that stalls mid-frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter  int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
  parameter  int unsigned BUSY_WAIT    = DEF_BUSY_WAIT,
  localparam int unsigned IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 CLK_10MHZ,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 frame_active,
  output logic                 err_timeout
);

  localparam int unsigned BUSY_W = $clog2(BUSY_WAIT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TIMEOUT + 1);

  arbState_t          state, stateNext;
  logic [BUSY_W-1:0]  busyCnt, busyCntNext;
  logic [HOLD_W-1:0]  holdCnt, holdCntNext;
  logic               lastByte, lastByteNext;
  logic [IDX_W-1:0]   grantNext, loadIdx, pickIdx;
  logic               pickValid, goLoad;
  logic               frameNext, timeoutNext, startNext;
  logic [NUM_REQ-1:0] readyNext;
  logic [7:0]         dataNext;

  rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
    .reqVec      (req_valid),
    .lastGrant   (grant_id),
    .pickValid_c (pickValid),
    .pickIdx_c   (pickIdx)
  );

  // Next state; start/ready/data are precomputed so they are registered
  // on entry to LOAD and tx_data is already stable under the start pulse.
  always_comb begin
    stateNext    = state;
    busyCntNext  = busyCnt;
    holdCntNext  = holdCnt;
    lastByteNext = lastByte;
    grantNext    = grant_id;
    frameNext    = frame_active;
    timeoutNext  = 1'b0;
    startNext    = 1'b0;
    readyNext    = '0;
    dataNext     = tx_data;
    loadIdx      = grant_id;
    goLoad       = 1'b0;

    case (state)
      // Idle also waits for tx_busy low so a byte still on the line is never overrun.
      ST_IDLE: begin
        if (pickValid && !tx_busy) begin
          loadIdx   = pickIdx;
          grantNext = pickIdx;
          frameNext = 1'b1;
          goLoad    = 1'b1;
        end
      end
      ST_LOAD: begin
        stateNext   = ST_WAIT_BUSY;
        busyCntNext = '0;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy || busyCnt == BUSY_W'(BUSY_WAIT - 1)) begin
          stateNext = ST_WAIT_DONE;
        end else if (busyCnt != BUSY_W'(BUSY_WAIT)) begin
          busyCntNext = busyCnt + BUSY_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (lastByte) begin
            frameNext = 1'b0;
            stateNext = ST_IDLE;
          end else if (req_valid[grant_id]) begin
            goLoad = 1'b1;
          end else begin
            stateNext   = ST_HOLD;
            holdCntNext = '0;
          end
        end
      end
      ST_HOLD: begin
        if (req_valid[grant_id]) begin
          goLoad      = 1'b1;
          holdCntNext = '0;
        end else if (holdCnt == HOLD_W'(HOLD_TIMEOUT - 1)) begin
          timeoutNext = 1'b1;
          frameNext   = 1'b0;
          stateNext   = ST_IDLE;
        end else if (holdCnt != HOLD_W'(HOLD_TIMEOUT)) begin
          holdCntNext = holdCnt + HOLD_W'(1);
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    if (goLoad) begin
      stateNext          = ST_LOAD;
      startNext          = 1'b1;
      readyNext[loadIdx] = 1'b1;
      dataNext           = req_data[{loadIdx, 3'b000} +: 8];
      lastByteNext       = req_last[loadIdx];
    end
  end

  always_ff @(posedge CLK_10MHZ or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      busyCnt      <= '0;
      holdCnt      <= '0;
      lastByte     <= 1'b0;
      grant_id     <= IDX_W'(NUM_REQ - 1);
      frame_active <= 1'b0;
      err_timeout  <= 1'b0;
      tx_start     <= 1'b0;
      req_ready    <= '0;
      tx_data      <= 8'h00;
    end else begin
      state        <= stateNext;
      busyCnt      <= busyCntNext;
      holdCnt      <= holdCntNext;
      lastByte     <= lastByteNext;
      grant_id     <= grantNext;
      frame_active <= frameNext;
      err_timeout  <= timeoutNext;
      tx_start     <= startNext;
      req_ready    <= readyNext;
      tx_data      <= dataNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a 230400 Bd busy
// model, a round-robin vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NREQ     = 4;
  localparam int          BYTE_CYC = int'((CLK_HZ * 10) / BAUD);

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        frame_active;
  logic        err_timeout;

  uart_tx_arbiter dut (
    .CLK_10MHZ    (clk),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .frame_active (frame_active),
    .err_timeout  (err_timeout)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // async_transmitter stand-in: busy from the cycle after a start for one 10-bit frame
  int   bcnt   = 0;
  logic busyEn = 1'b1;
  always @(posedge clk) begin
    if (busyEn && tx_start) bcnt <= BYTE_CYC;
    else if (bcnt != 0)     bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Requester byte queues: {last, data}; valid while non-empty
  logic [8:0] mem [NREQ][16];
  int head [NREQ];
  int tail [NREQ];

  task automatic push(input int i, input logic last, input logic [7:0] b);
    mem[i][tail[i]] = {last, b};
    tail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = mem[i][head[i]][7:0];
        req_last[i]         = mem[i][head[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  function automatic logic allEmpty();
    logic e = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  initial begin
    logic [3:0] rdy;
    for (int i = 0; i < int'(NREQ); i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NREQ); i++) if (rdy[i] && head[i] != tail[i]) head[i]++;
      drive();
    end
  end

  // Start-pulse log and one-hot ready invariant
  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [1:0] gid;
    logic       busyBefore;
  } txEv_t;

  txEv_t txLog[$];
  int    cyc       = 0;
  int    errPulses = 0;
  logic  prevBusy  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        txEv_t e;
        e.cyc        = cyc;
        e.data       = tx_data;
        e.gid        = grant_id;
        e.busyBefore = prevBusy;
        txLog.push_back(e);
      end
      if (err_timeout) errPulses++;
      if (req_ready != 4'b0) chk("ready_onehot_in_load", 32'({$onehot(req_ready), tx_start}), 32'(2'b11));
      prevBusy = tx_busy;
    end
  end

  task automatic waitStarts(input int n, input int budget, input string name);
    int c = 0;
    while (txLog.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(name, 32'(txLog.size()), 32'(n));
  endtask

  task automatic waitIdle(input int budget, input string name);
    int c = 0;
    while ((frame_active || !allEmpty()) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(name, 32'(frame_active), 32'(0));
  endtask

  task automatic chkEv(input int idx, input string name, input logic [7:0] expData, input logic [1:0] expGid);
    if (txLog.size() > idx) begin
      chk({name, "_data"}, 32'(txLog[idx].data), 32'(expData));
      chk({name, "_gid"}, 32'(txLog[idx].gid), 32'(expGid));
    end else begin
      chk({name, "_present"}, 32'(txLog.size()), 32'(idx + 1));
    end
  endtask

  task automatic chkResetOutputs(input string name);
    chk({name, "_ready"}, 32'(req_ready), 32'(0));
    chk({name, "_start"}, 32'(tx_start), 32'(0));
    chk({name, "_data"}, 32'(tx_data), 32'(0));
    chk({name, "_grant"}, 32'(grant_id), 32'(3));
    chk({name, "_active"}, 32'(frame_active), 32'(0));
    chk({name, "_timeout"}, 32'(err_timeout), 32'(0));
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] expFirst;
    logic [1:0] expEnd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int gap;
    int n;
    vecs[0] = '{mask: 4'b1000, expFirst: 2'd3, expEnd: 2'd3};
    vecs[1] = '{mask: 4'b1001, expFirst: 2'd0, expEnd: 2'd3};
    vecs[2] = '{mask: 4'b0110, expFirst: 2'd1, expEnd: 2'd2};
    vecs[3] = '{mask: 4'b1111, expFirst: 2'd3, expEnd: 2'd2};
    vecs[4] = '{mask: 4'b0001, expFirst: 2'd0, expEnd: 2'd0};
    vecs[5] = '{mask: 4'b0101, expFirst: 2'd2, expEnd: 2'd0};

    RST = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkResetOutputs("reset");
    @(negedge clk);
    RST = 1'b0;

    // Single three-byte frame with latency and spacing
    repeat (2) @(negedge clk);
    txLog.delete();
    push(0, 1'b0, 8'h31);
    push(0, 1'b0, 8'h32);
    push(0, 1'b1, 8'h0A);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid[0]) break;
    end
    chk("lat_start_before", 32'(tx_start), 32'(0));
    @(negedge clk);
    chk("lat_start_after", 32'(tx_start), 32'(1));
    chk("lat_ready", 32'(req_ready), 32'(4'b0001));
    waitStarts(3, 1600, "single_starts");
    chkEv(0, "single_b0", 8'h31, 2'd0);
    chkEv(1, "single_b1", 8'h32, 2'd0);
    chkEv(2, "single_b2", 8'h0A, 2'd0);
    if (txLog.size() >= 3) begin
      gap = txLog[1].cyc - txLog[0].cyc;
      chk("single_gap01", 32'(gap >= 430 && gap <= 445), 32'(1));
      gap = txLog[2].cyc - txLog[1].cyc;
      chk("single_gap12", 32'(gap >= 430 && gap <= 445), 32'(1));
    end
    waitIdle(600, "single_idle");
    if (txLog.size() >= 3) chk("single_drop_after_last", 32'(cyc > txLog[2].cyc + 430), 32'(1));

    // Contention right after reset
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    txLog.delete();
    push(1, 1'b0, 8'hA1);
    push(1, 1'b1, 8'hA2);
    push(2, 1'b0, 8'hB1);
    push(2, 1'b1, 8'hB2);
    waitStarts(4, 2200, "cont_starts");
    chkEv(0, "cont_e0", 8'hA1, 2'd1);
    chkEv(1, "cont_e1", 8'hA2, 2'd1);
    chkEv(2, "cont_e2", 8'hB1, 2'd2);
    chkEv(3, "cont_e3", 8'hB2, 2'd2);
    waitIdle(600, "cont_idle");
    chk("cont_end_grant", 32'(grant_id), 32'(2));

    // Round-robin table of one-byte frames
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      txLog.delete();
      n = 0;
      for (int i = 0; i < 4; i++) begin
        if (vecs[v].mask[i]) begin
          push(i, 1'b1, 8'(8'h60 + 16 * v + i));
          n++;
        end
      end
      waitStarts(n, n * 500 + 50, $sformatf("rr%0d_starts", v));
      waitIdle(600, $sformatf("rr%0d_idle", v));
      chkEv(0, $sformatf("rr%0d_first", v), 8'(8'h60 + 16 * v + int'(vecs[v].expFirst)), vecs[v].expFirst);
      chk($sformatf("rr%0d_end_grant", v), 32'(grant_id), 32'(vecs[v].expEnd));
      chk($sformatf("rr%0d_count", v), 32'(txLog.size()), 32'(n));
    end

    // Owner stalls mid-frame until forced release
    @(negedge clk);
    txLog.delete();
    errPulses = 0;
    push(2, 1'b0, 8'hC1);
    push(3, 1'b1, 8'hD1);
    waitStarts(1, 50, "stall_first_start");
    chkEv(0, "stall_first", 8'hC1, 2'd2);
    waitStarts(2, 22000, "stall_next_start");
    chk("stall_err_pulses", 32'(errPulses), 32'(1));
    chkEv(1, "stall_next", 8'hD1, 2'd3);
    if (txLog.size() >= 2) begin
      gap = txLog[1].cyc - txLog[0].cyc;
      chk("stall_gap", 32'(gap >= 20000 && gap <= 20500), 32'(1));
    end
    waitIdle(600, "stall_idle");
    chk("stall_total_starts", 32'(txLog.size()), 32'(2));
    chk("stall_err_once", 32'(errPulses), 32'(1));

    // Transmitter never raises busy
    @(negedge clk);
    busyEn = 1'b0;
    txLog.delete();
    push(0, 1'b0, 8'hE1);
    push(0, 1'b1, 8'hE2);
    waitStarts(2, 100, "nobusy_starts");
    if (txLog.size() >= 2) chk("nobusy_gap", 32'(txLog[1].cyc - txLog[0].cyc), 32'(10));
    chkEv(1, "nobusy_b1", 8'hE2, 2'd0);
    waitIdle(100, "nobusy_idle");
    @(negedge clk);
    busyEn = 1'b1;

    // Reset while the owner waits for the byte to finish
    @(negedge clk);
    txLog.delete();
    push(1, 1'b0, 8'hF1);
    push(1, 1'b1, 8'hF2);
    waitStarts(1, 50, "rstmid_first_start");
    repeat (40) @(posedge clk);
    #1;
    chk("rstmid_active_before", 32'(frame_active), 32'(1));
    @(posedge clk);
    #2;
    RST = 1'b1;
    #1;
    chkResetOutputs("rstmid");
    chk("rstmid_byte_kept", 32'({req_valid[1], req_data[15:8]}), 32'({1'b1, 8'hF2}));
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_busy_still_high", 32'(tx_busy), 32'(1));
    RST = 1'b0;
    waitStarts(2, 600, "rstmid_restart_start");
    chkEv(1, "rstmid_restart", 8'hF2, 2'd1);
    if (txLog.size() >= 2) chk("rstmid_busy_low_before", 32'(txLog[1].busyBefore), 32'(0));
    waitIdle(600, "rstmid_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters sharing one async_transmitter.
REQ-002 Parameter HOLD_TIMEOUT, default 20000, cycles an owner may stall mid-frame before forced release (2 ms at 10 MHz).
REQ-003 Parameter BUSY_WAIT, default 8, cycles allowed for TxD_busy to rise after a start pulse.
REQ-004 CLK_10MHZ  in  1  sole clock, 10 MHz.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  requester i has a byte on req_data slice i.
REQ-007 req_data  in  8*NUM_REQ  bytes, requester i in bits [8i+7:8i].
REQ-008 req_last  in  NUM_REQ  byte on slice i ends its frame.
REQ-009 req_ready  out  NUM_REQ  one-cycle accept pulse; byte i consumed.
REQ-010 tx_start  out  1  to TxD_start; one-cycle pulse.
REQ-011 tx_data  out  8  to TxD_data; held stable from the start pulse until the byte completes.
REQ-012 tx_busy  in  1  from TxD_busy.
REQ-013 grant_id  out  clog2(NUM_REQ)  current or last owner index.
REQ-014 frame_active  out  1  an owner holds the transmitter.
REQ-015 err_timeout  out  1  one-cycle pulse on forced release.

Function
REQ-016 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-017 IDLE: if any req_valid, select the first asserted index searching round-robin from grant_id+1 (mod NUM_REQ), latch it into grant_id, set frame_active, go LOAD; otherwise stay.
REQ-018 LOAD, exactly one cycle: tx_data <= req_data[owner], tx_start = 1, req_ready[owner] = 1, latch req_last[owner]; go WAIT_BUSY.
REQ-019 Latency: req_valid sampled in IDLE at cycle N gives tx_start and req_ready high at cycle N+1.
REQ-020 WAIT_BUSY: on tx_busy = 1 go WAIT_DONE; after BUSY_WAIT cycles without it, go WAIT_DONE anyway.
REQ-021 WAIT_DONE: stay while tx_busy = 1. On tx_busy = 0: if latched last, clear frame_active and go IDLE; else if req_valid[owner], go LOAD; else go HOLD.
REQ-022 HOLD: on req_valid[owner] go LOAD and clear the hold counter. After HOLD_TIMEOUT cycles, pulse err_timeout, clear frame_active and go IDLE.
REQ-023 Non-owner req_valid is ignored while frame_active = 1; bytes of different frames never interleave.
REQ-024 Only one req_ready bit is ever high, and only in LOAD.
REQ-025 Requesters keep req_data and req_last stable while req_valid = 1 and req_ready = 0.
REQ-026 A requester that drops req_valid before its ready pulse loses nothing; the arbiter only consumes in LOAD.
REQ-027 Round-robin wraps from NUM_REQ-1 to 0. After reset, the search starts at index 0.
REQ-028 Hold and busy-wait counters saturate and never wrap.

Reset
REQ-029 While RST is high: state IDLE, req_ready = 0, tx_start = 0, tx_data = 0x00, grant_id = NUM_REQ-1, frame_active = 0, err_timeout = 0, counters = 0.
REQ-030 RST mid-frame aborts the frame with no ready pulse. The byte already in async_transmitter finishes on its own.
REQ-031 After RST falls, no tx_start is issued before tx_busy has been sampled low.

Structure
REQ-032 Shared package uart_pkg holds the state enumeration, the default NUM_REQ, HOLD_TIMEOUT and BUSY_WAIT, and the CLK_HZ = 10000000 / BAUD = 230400 constants used by async_transmitter.
REQ-033 One sub-module, rr_pick: combinational round-robin priority selector (request vector, last grant) -> (valid, index).
REQ-034 The top level instantiates uart_tx_arbiter between the frame producers and async_transmitter, replacing inline byte sequencing.

Verification
REQ-035 Single frame: req0 sends 0x31,0x32,last 0x0A while the bench models 230400 Bd busy -> three tx_start pulses in that order, each about 43 us apart; frame_active drops after 0x0A.
REQ-036 Contention: req1 and req2 raise valid in the same cycle after reset -> req1 gets its whole 2-byte frame first, then req2; grant_id goes 1 then 2.
REQ-037 Wrap: grant_id = 3 with req0 and req3 valid -> req0 is granted.
REQ-038 Stall: req2 sends a non-last byte then drops valid for 20000 cycles -> err_timeout pulses once, req3 (already valid) is granted next, and no req2 byte is sent in between.
REQ-039 Missing busy: tx_busy held 0 -> after 8 cycles the FSM proceeds; the next tx_start comes no earlier than cycle 10 after the first.
REQ-040 Reset in WAIT_DONE -> all outputs take their REQ-029 values within the same cycle; the first new tx_start follows tx_busy low.
